// File: rtl/counter_sequence_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// counter_sequence_controller : run/stop/pause sequencer for a binary counter
// Rev 1.0
// ---------------------------------------------------------------------------
module counter_sequence_controller #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             not_RST,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             up_down,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_count, w_count;
  logic [WIDTH-1:0] r_load, w_load;
  logic [WIDTH-1:0] r_term, w_term;
  logic             r_up, w_up;
  logic             r_mode, w_mode;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_wrap, w_wrap;

  always_ff @(posedge CLK or negedge not_RST) begin
    if (!not_RST) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_load  <= '0;
      r_term  <= '0;
      r_up    <= 1'b0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_count <= w_count;
      r_load  <= w_load;
      r_term  <= w_term;
      r_up    <= w_up;
      r_mode  <= w_mode;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_wrap  <= w_wrap;
    end
  end

  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_load  = r_load;
    w_term  = r_term;
    w_up    = r_up;
    w_mode  = r_mode;
    w_done  = 1'b0;
    w_wrap  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_state = S_RUN;
          w_count = load_val;
          w_load  = load_val;
          w_term  = term_val;
          w_up    = up_down;
          w_mode  = mode;
        end
      end
      S_RUN: begin
        // stop beats pause beats the terminal check beats counting
        if (stop) begin
          w_state = S_IDLE;
        end else if (pause) begin
          w_state = S_RUN;
        end else if (r_count == r_term) begin
          if (!r_mode) begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end else begin
            w_count = r_load;
            w_wrap  = 1'b1;
          end
        end else begin
          w_count = r_up ? (r_count + c_ONE) : (r_count - c_ONE);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    // busy is registered from the next state so it tracks RUN with no input path
    w_busy = (w_state == S_RUN);
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;
  assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequence_controller.sv
`default_nettype none
// Directed table-driven bench for counter_sequence_controller plus
// hand-written pause and asynchronous-reset sequences.
module tb_counter_sequence_controller;

  logic       CLK = 1'b0;
  logic       not_RST = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, up_down = 1'b0, mode = 1'b0;
  logic [2:0] load_val = '0, term_val = '0;
  logic [2:0] count;
  logic       busy, done, wrap;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       st, sp, pa, ud, md;
    logic [2:0] ld, tm;
    logic [2:0] c;
    logic       b, d, w;
  } vec_t;

  vec_t tbl[$];

  counter_sequence_controller #(.WIDTH(3)) dut (
    .CLK      (CLK),
    .not_RST  (not_RST),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .up_down  (up_down),
    .mode     (mode),
    .load_val (load_val),
    .term_val (term_val),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic st, sp, pa, ud, md, input logic [2:0] ld, tm, c,
                     input logic b, d, w);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.ud = ud; v.md = md;
    v.ld = ld; v.tm = tm; v.c = c; v.b = b; v.d = d; v.w = w;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [2:0] c, input logic b, d, w);
    n_vec++;
    if (count !== c || busy !== b || done !== d || wrap !== w) begin
      n_err++;
      $display("FAIL %s: got count=%0d busy=%b done=%b wrap=%b, expected count=%0d busy=%b done=%b wrap=%b",
               name, count, busy, done, wrap, c, b, d, w);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic st, sp, pa, ud, md, input logic [2:0] ld, tm);
    start = st; stop = sp; pause = pa; up_down = ud; mode = md;
    load_val = ld; term_val = tm;
  endtask

  initial begin
    // st sp pa ud md ld tm | count busy done wrap
    // one-shot up 2->5, term_val changed mid-run must be ignored
    add(1,0,0,1,0,2,5, 2,1,0,0);
    add(0,0,0,0,1,0,3, 3,1,0,0);
    add(0,0,0,0,1,0,3, 4,1,0,0);
    add(0,0,0,0,1,0,3, 5,1,0,0);
    add(0,0,0,0,1,0,3, 5,0,1,0);
    add(0,0,0,0,1,0,3, 5,0,0,0);
    add(0,0,0,0,1,0,3, 5,0,0,0);
    // one-shot down through the wrap 1,0,7,6
    add(1,0,0,0,0,1,6, 1,1,0,0);
    add(0,0,0,1,1,1,6, 0,1,0,0);
    add(0,0,0,1,1,1,6, 7,1,0,0);
    add(0,0,0,1,1,1,6, 6,1,0,0);
    add(0,0,0,1,1,1,6, 6,0,1,0);
    add(0,0,0,1,1,1,6, 6,0,0,0);
    // auto-reload up 6,7,0,1 period 4, then stop
    add(1,0,0,1,1,6,1, 6,1,0,0);
    add(0,0,0,0,0,0,0, 7,1,0,0);
    add(0,0,0,0,0,0,0, 0,1,0,0);
    add(0,0,0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0,0,0, 6,1,0,1);
    add(0,0,0,0,0,0,0, 7,1,0,0);
    add(0,0,0,0,0,0,0, 0,1,0,0);
    add(0,0,0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0,0,0, 6,1,0,1);
    add(0,1,0,0,0,0,0, 6,0,0,0);
    // start and stop together in IDLE
    add(1,1,0,1,0,3,5, 6,0,0,0);
    // load==term one-shot
    add(1,0,0,1,0,4,4, 4,1,0,0);
    add(0,0,0,1,0,4,4, 4,0,1,0);
    add(0,0,0,1,0,4,4, 4,0,0,0);
    // load==term auto-reload
    add(1,0,0,1,1,2,2, 2,1,0,0);
    add(0,0,0,1,1,2,2, 2,1,0,1);
    add(0,0,0,1,1,2,2, 2,1,0,1);
    add(0,1,0,1,1,2,2, 2,0,0,0);
    // start held high through RUN and DONE
    add(1,0,0,1,0,7,0, 7,1,0,0);
    add(1,0,0,1,0,7,0, 0,1,0,0);
    add(1,0,0,1,0,7,0, 0,0,1,0);
    add(1,0,0,1,0,7,0, 0,0,0,0);
    add(1,0,0,1,0,7,0, 7,1,0,0);
    add(0,1,0,1,0,7,0, 7,0,0,0);
    // stop at count==term: no done
    add(1,0,0,1,0,1,3, 1,1,0,0);
    add(0,0,0,1,0,1,3, 2,1,0,0);
    add(0,0,0,1,0,1,3, 3,1,0,0);
    add(0,1,0,1,0,1,3, 3,0,0,0);
    add(0,0,0,1,0,1,3, 3,0,0,0);

    not_RST = 1'b0;
    #12;
    chk("reset_state", 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    not_RST = 1'b1;
    step();
    chk("idle_after_reset", 3'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].ud, tbl[i].md, tbl[i].ld, tbl[i].tm);
      step();
      chk($sformatf("vec%0d", i), tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].w);
    end

    // pause held 3 cycles at count=3 in a one-shot 0->7
    drive(1,0,0,1,0,3'd0,3'd7);
    step();
    chk("pause_start", 3'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("pause_pre%0d", k), 3'(k), 1'b1, 1'b0, 1'b0);
    end
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("pause_hold%0d", k), 3'd3, 1'b1, 1'b0, 1'b0);
    end
    pause = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      step();
      chk($sformatf("pause_post%0d", k), 3'(k), 1'b1, 1'b0, 1'b0);
    end
    step();
    chk("pause_done", 3'd7, 1'b0, 1'b1, 1'b0);
    step();
    chk("pause_idle", 3'd7, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-RUN at count=5
    drive(1,0,0,1,1,3'd3,3'd7);
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_reset_count5", 3'd5, 1'b1, 1'b0, 1'b0);
    #2;
    not_RST = 1'b0;
    #1;
    chk("async_reset", 3'd0, 1'b0, 1'b0, 1'b0);
    #2;
    not_RST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_reset_idle%0d", k), 3'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_sequence_controller.md
# counter_sequence_controller

Synchronous run/stop sequencer for a small binary counter. It loads a start value, counts up or down one step per clock toward a programmable terminal value, then either stops with a done pulse (one-shot) or reloads and keeps running (auto-reload). It is the control layer for the lab counter datapaths: it starts, pauses, stops and re-arms a counter, and replaces hand-driven reset/preset sequencing.

## Interface
Parameters:
- WIDTH, 3, counter width in bits; all count arithmetic is modulo 2^WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- not_RST  input  1  reset, asynchronous, active-low.
- start  input  1  level; sampled only in IDLE.
- stop  input  1  level; abort to IDLE; highest-priority control.
- pause  input  1  level; freezes the count in RUN.
- up_down  input  1  1 = count up, 0 = count down; latched at start.
- mode  input  1  0 = one-shot, 1 = auto-reload; latched at start.
- load_val  input  WIDTH  start/reload value; latched at start.
- term_val  input  WIDTH  terminal value; latched at start.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on one-shot completion.
- wrap  output  1  one-cycle pulse on each auto-reload.

## Operation
- States: IDLE, RUN, DONE. State is encoded internally and not exported.
- Reset (not_RST low, at any time, asynchronously): state=IDLE, count=0, busy=0, done=0, wrap=0. Latched config is cleared to 0.
- IDLE:
  - If start=1 and stop=0, on that edge: count<=load_val; latch up_down, mode, load_val and term_val; go to RUN.
  - Otherwise count holds.
- RUN, evaluated on each edge in this priority order:
  1. stop=1: go to IDLE, count holds, no done or wrap.
  2. pause=1: hold count, stay in RUN, no terminal check.
  3. count==term (latched), mode=0: go to DONE, count holds, done<=1.
  4. count==term (latched), mode=1: count<=load (latched), wrap<=1, stay in RUN.
  5. Otherwise: count<=count+1 (up) or count-1 (down), mod 2^WIDTH.
- DONE: always goes to IDLE on the next edge. done returns to 0. start and stop are ignored in this state.
- start while in RUN or DONE is ignored. Input config changes after start have no effect until the next start from IDLE.
- Wrap-around: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1. The terminal value may lie "behind" the load value; the counter passes through the wrap to reach it.
- load_val==term_val:
  - One-shot: done fires on the first RUN edge.
  - Auto-reload: wrap pulses every cycle and count stays constant.

## Timing
- busy, done and wrap are registered, with no combinational path from any input.
- Start latency: count shows load_val in the cycle after the start edge, and busy=1 from that cycle.
- One-shot: with N = (term-load) mod 2^WIDTH for up, or (load-term) mod 2^WIDTH for down, done is high in the cycle after edge N+1 following the start edge. busy falls in the same cycle done rises.
- Auto-reload period is N+1 cycles when pause is not asserted. wrap is high for exactly 1 cycle per period.
- Each pause cycle extends the sequence by exactly one cycle.
- stop takes effect on the edge it is sampled. busy=0 in the next cycle.
- Reset mid-operation: outputs clear immediately, without waiting for a clock edge. After not_RST is released, the block stays in IDLE until a fresh start.

## Test plan
- Reset: pulse not_RST low mid-RUN with count=5 → count=0, busy=0, done=0 and wrap=0 immediately, before the next clock edge; the block stays in IDLE without start.
- One-shot up: load=2, term=5, up, mode=0, start for 1 cycle → count 2,3,4,5 on successive cycles; done=1 for one cycle with count=5; busy 1→0 at the same time; then IDLE.
- Down with wrap: load=1, term=6, down, mode=0 → count 1,0,7,6, then done. Auto-reload up with load=6, term=1 → 6,7,0,1,6,...; wrap=1 in each cycle count=6 follows 1; period 4.
- Pause and stop: one-shot load=0, term=7, pause held 3 cycles at count=3 → count stays 3; done arrives 3 cycles later than without pause. Stop asserted at count==term → IDLE, count holds, no done pulse.
- Priority and latching:
  - start=stop=1 in IDLE → stays IDLE.
  - Change term_val during RUN → latched value is still used.
  - start held high through DONE → ignored in DONE; a new run begins from IDLE on the next edge.
- load==term: one-shot → done on the first RUN edge. Auto-reload → wrap every cycle, count constant.
